// File: rtl/step_profile_gen_if.sv
// Command/status bundle between the motion command logic (master) and the
// step pulse generator (slave). Port names keep the generator's pin names.
interface step_profile_gen_if #(
    parameter int SIZE = 32
);
    logic            enable_i;
    logic [SIZE-1:0] steps_i;
    logic            done_o;
    logic            step_o;
    logic            dir_o;
    logic [SIZE-1:0] position_o;

    modport master (
        output enable_i, steps_i,
        input  done_o, step_o, dir_o, position_o
    );

    modport slave (
        input  enable_i, steps_i,
        output done_o, step_o, dir_o, position_o
    );
endinterface

// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator for one stepper axis.
// A rising edge on enable_i starts a move of |steps_i| pulses; the step
// period ramps from PERIOD_MAX down to PERIOD_MIN, cruises, then ramps back
// up symmetrically so the axis stops at PERIOD_MAX.
// All timing is derived from clk_i through a tick clock enable.
// Optional feature: define STEP_PROFILE_ABORT_EN to let a falling edge of
// enable_i during ACCEL/CRUISE cut the move short with a smooth decel.
module step_profile_gen #(
    parameter int SIZE        = 32,
    parameter int SYSCLK      = 25000000,
    parameter int TICK_HZ     = 1000000,
    parameter int PERIOD_MAX  = 26000,
    parameter int PERIOD_MIN  = 6000,
    parameter int ACCEL_STEP  = 2,
    parameter int PULSE_TICKS = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    step_profile_gen_if.slave  bus
);

    localparam int TICK_DIV = SYSCLK / TICK_HZ;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [31:0]      P_MAX      = 32'(PERIOD_MAX);
    localparam logic [31:0]      P_MIN      = 32'(PERIOD_MIN);
    localparam logic [31:0]      ACC        = 32'(ACCEL_STEP);
    localparam logic [31:0]      PULSE_LAST = 32'(PULSE_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [31:0]      tick_cnt, tick_cnt_n;
    logic [31:0]      period, period_n;
    logic [SIZE-1:0]  ramp, ramp_n;
    logic [SIZE-1:0]  rem, rem_n;
    logic             enable_q;
    logic             step, step_n;
    logic             dir, dir_n;
    logic             done, done_n;
    logic [SIZE-1:0]  position, position_n;

    logic             tick;
    logic             start_edge;
    logic             emit;
    logic             pulse_end;
    logic [SIZE-1:0]  magnitude;
    logic [31:0]      period_dn;
    logic [32:0]      up_sum;
    logic [31:0]      period_up;

    assign tick       = (div_cnt == DIV_LAST);
    assign start_edge = bus.enable_i & ~enable_q;
    // The most negative count negates to itself, which read unsigned is 2^(SIZE-1).
    assign magnitude  = bus.steps_i[SIZE-1] ? (~bus.steps_i + SIZE'(1)) : bus.steps_i;

    // A step is due when the period-th tick since the last emission arrives.
    assign emit       = (state != IDLE) && tick && (rem != '0) && (tick_cnt == period - 32'd1);
    assign pulse_end  = step && tick && (tick_cnt == PULSE_LAST);

    // Saturating ramp arithmetic; the period never leaves [PERIOD_MIN, PERIOD_MAX].
    assign period_dn  = ((period <= P_MIN) || ((period - P_MIN) <= ACC)) ? P_MIN : (period - ACC);
    assign up_sum     = {1'b0, period} + {1'b0, ACC};
    assign period_up  = (up_sum >= {1'b0, P_MAX}) ? P_MAX : up_sum[31:0];

`ifdef STEP_PROFILE_ABORT_EN
    logic fall_edge;
    assign fall_edge = ~bus.enable_i & enable_q;
`endif

    // Next-state, profile and output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_n    = state;
        div_n      = tick ? '0 : div_cnt + DIV_W'(1);
        tick_cnt_n = tick_cnt;
        period_n   = period;
        ramp_n     = ramp;
        rem_n      = rem;
        step_n     = step;
        dir_n      = dir;
        done_n     = done;
        position_n = position;

        case (state)
            IDLE: begin
                if (start_edge && (magnitude != '0)) begin
                    state_n    = ACCEL;
                    dir_n      = bus.steps_i[SIZE-1];
                    rem_n      = magnitude;
                    period_n   = P_MAX;
                    ramp_n     = '0;
                    tick_cnt_n = '0;
                    div_n      = '0;
                end
            end

            default: begin
                // done_o drops on the first edge spent outside IDLE.
                done_n = 1'b0;
                if (tick) begin
                    tick_cnt_n = tick_cnt + 32'd1;
                end

                if (pulse_end) begin
                    step_n = 1'b0;
                    if (rem == '0) begin
                        state_n    = IDLE;
                        done_n     = 1'b1;
                        tick_cnt_n = '0;
                    end
                end

                if (emit) begin
                    step_n     = 1'b1;
                    tick_cnt_n = '0;
                    position_n = dir ? (position - SIZE'(1)) : (position + SIZE'(1));
                    rem_n      = rem - SIZE'(1);
                    if ((state == ACCEL) && (period > P_MIN)) begin
                        ramp_n = ramp + SIZE'(1);
                    end
                    if (rem_n == '0) begin
                        // Last pulse: the move ends when this pulse falls.
                    end else if (rem_n <= ramp_n) begin
                        state_n  = DECEL;
                        period_n = period_up;
                    end else if (state == ACCEL) begin
                        period_n = period_dn;
                        if (period_dn == P_MIN) begin
                            state_n = CRUISE;
                        end
                    end else if (state == DECEL) begin
                        period_n = period_up;
                    end
                end

`ifdef STEP_PROFILE_ABORT_EN
                // Abort: only as many steps remain as the ramp needs to unwind.
                if (fall_edge && ((state == ACCEL) || (state == CRUISE)) && (state_n != IDLE)) begin
                    rem_n   = (ramp_n < rem_n) ? ramp_n : rem_n;
                    state_n = DECEL;
                    if ((rem_n == '0) && !step_n) begin
                        // Nothing left to unwind and no pulse in flight: stop now.
                        state_n    = IDLE;
                        done_n     = 1'b1;
                        tick_cnt_n = '0;
                    end
                end
`endif
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            period   <= P_MAX;
            ramp     <= '0;
            rem      <= '0;
            enable_q <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b0;
            done     <= 1'b1;
            position <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_n;
            div_cnt  <= div_n;
            tick_cnt <= tick_cnt_n;
            period   <= period_n;
            ramp     <= ramp_n;
            rem      <= rem_n;
            enable_q <= bus.enable_i;
            step     <= step_n;
            dir      <= dir_n;
            done     <= done_n;
            position <= position_n;
        end
    end

    assign bus.step_o     = step;
    assign bus.dir_o      = dir;
    assign bus.done_o     = done;
    assign bus.position_o = position;

endmodule
